gold_shift_scheduler: RTL

GOLD_SHIFT_SCHEDULER -- requirements
Module: gold_shift_scheduler

---
 rtl/gold_shift_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/gold_shift_scheduler.sv
// ---------------------------------------------------------------------------
// gold_shift_scheduler
//
// Epoch-driven round-robin scheduler that hands out bursts of Gold-code shift
// indices on an AXI-stream port. Once per epoch the level requests are
// sampled into a pending mask. Pending requesters are then served one burst at
// a time in round-robin order. Each burst emits consecutive shift indices that
// wrap modulo N.
//
// Ports
//   clkin          clock
//   rstn           synchronous active-low reset
//   req_valid      [NREQ]          level request per requester
//   req_start      [NREQ*LENGTH]   start shift, requester i at [i*LENGTH +: LENGTH]
//   req_count      [NREQ*CW]       burst length, requester i at [i*CW +: CW]
//   req_ack        [NREQ]          one-cycle pulse when a burst completes or is skipped
//   m_tvalid       stream valid
//   m_tready       stream ready
//   m_tdata        [LENGTH]        shift index
//   m_tuser        [IDW]           granted requester id
//   m_tlast        last beat of burst
//   epoch_tick     one-cycle pulse every EPOCH_CYCLES cycles
//   epoch_overrun  one-cycle pulse when a tick finds work still pending
// ---------------------------------------------------------------------------
module gold_shift_scheduler #(
    parameter int NREQ         = 4,
    parameter int N            = 63,
    parameter int LENGTH       = $clog2(N),
    parameter int MAX_BURST    = 8,
    parameter int EPOCH_CYCLES = 100000,
    parameter int CW           = $clog2(MAX_BURST + 1),
    parameter int IDW          = $clog2(NREQ)
) (
    input  logic                   clkin,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*LENGTH-1:0] req_start,
    input  logic [NREQ*CW-1:0]     req_count,
    output logic [NREQ-1:0]        req_ack,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [LENGTH-1:0]      m_tdata,
    output logic [IDW-1:0]         m_tuser,
    output logic                   m_tlast,
    output logic                   epoch_tick,
    output logic                   epoch_overrun
);

    localparam int EW = (EPOCH_CYCLES > 1) ? $clog2(EPOCH_CYCLES) : 1;
    localparam logic [EW-1:0]     EPOCH_RELOAD = EW'(EPOCH_CYCLES - 1);
    // One extra bit so that a code length of exactly 2**LENGTH still compares.
    localparam logic [LENGTH:0]   N_WIDE       = (LENGTH + 1)'(N);
    localparam logic [LENGTH-1:0] LAST_IDX     = LENGTH'(N - 1);
    localparam logic [CW-1:0]     MAXB         = CW'(MAX_BURST);
    localparam logic [IDW-1:0]    LAST_ID      = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [NREQ-1:0]   pending_q, pending_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [EW-1:0]     epoch_q, epoch_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [LENGTH-1:0] data_q, data_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     len_q, len_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic              tick;
    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [LENGTH-1:0] grant_start_raw;
    logic [CW-1:0]     grant_count_raw;
    logic [LENGTH-1:0] grant_start;
    logic [CW-1:0]     grant_len;
    logic              in_burst;
    logic              last_beat;
    logic              handshake;
    logic              burst_done;
    logic              skip;
    logic [NREQ-1:0]   ack_mask;

    assign tick = (epoch_q == '0);

    // Round-robin search: first pending index at or after rr_q, wrapping.
    // The requester's start/count are picked up in the same pass.
    always_comb begin
        int idx;
        idx             = 0;
        grant_found     = 1'b0;
        grant_id        = '0;
        grant_start_raw = '0;
        grant_count_raw = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!grant_found && pending_q[idx]) begin
                grant_found     = 1'b1;
                grant_id        = IDW'(idx);
                grant_start_raw = req_start[idx*LENGTH +: LENGTH];
                grant_count_raw = req_count[idx*CW +: CW];
            end
        end
    end

    // Out-of-range starts restart the code at phase 0; long bursts are clamped.
    assign grant_start = ({1'b0, grant_start_raw} >= N_WIDE) ? '0 : grant_start_raw;
    assign grant_len   = (grant_count_raw > MAXB) ? MAXB : grant_count_raw;

    assign in_burst   = (state_q == S_BURST);
    assign last_beat  = (beat_q == len_q - 1'b1);
    assign handshake  = in_burst && m_tready;
    assign burst_done = handshake && last_beat;
    // A zero-length grant is acknowledged straight from ARB without any beat.
    assign skip       = (state_q == S_ARB) && grant_found && (grant_len == '0);

    // -----------------------------------------------------------------------
    // State register (including datapath registers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            rr_q      <= '0;
            epoch_q   <= EPOCH_RELOAD;
            id_q      <= '0;
            data_q    <= '0;
            beat_q    <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            epoch_q   <= epoch_d;
            id_q      <= id_d;
            data_q    <= data_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Looking at pending_d lets a tick reach ARB in the next cycle.
                if (|pending_d) state_d = S_ARB;
            end
            S_ARB: begin
                if (!grant_found)          state_d = S_IDLE;
                else if (grant_len == '0)  state_d = (|pending_d) ? S_ARB : S_IDLE;
                else                       state_d = S_BURST;
            end
            S_BURST: begin
                if (burst_done) state_d = (|pending_d) ? S_ARB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        ack_mask = '0;
        if (skip)       ack_mask[grant_id] = 1'b1;
        if (burst_done) ack_mask[id_q]     = 1'b1;

        m_tvalid = in_burst;
        m_tdata  = in_burst ? data_q : '0;
        m_tuser  = in_burst ? id_q : '0;
        m_tlast  = in_burst && last_beat;

        // Pulses are suppressed in a reset cycle so an aborted burst never acks.
        req_ack       = rstn ? ack_mask : '0;
        epoch_tick    = rstn && tick;
        epoch_overrun = rstn && tick && (|pending_q);
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        epoch_d = tick ? EPOCH_RELOAD : (epoch_q - 1'b1);

        // Ack clears first so a bit set by a same-cycle tick survives.
        pending_d = (pending_q & ~ack_mask) | (tick ? req_valid : '0);

        rr_d   = rr_q;
        id_d   = id_q;
        data_d = data_q;
        beat_d = beat_q;
        len_d  = len_q;

        if (skip) begin
            rr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end else if ((state_q == S_ARB) && grant_found) begin
            id_d   = grant_id;
            data_d = grant_start;
            len_d  = grant_len;
            beat_d = '0;
        end

        if (burst_done) begin
            rr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        end else if (handshake) begin
            beat_d = beat_q + 1'b1;
            data_d = (data_q == LAST_IDX) ? '0 : data_q + 1'b1;
        end
    end

endmodule
